uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Parametrised UART command-frame parser, the successor to the fixed-length command decoder. Sits between the UART RX module and the SDRAM write FIFO / read-control logic. Recognises write and read command frames and forwards the write payload into the write FIFO. Adds an optional XOR checksum, an inter-byte timeout, error reporting and a FIFO-flush request on bad frames.

Parameters:
DATA_W, 8, UART byte width
PAYLOAD_NUM, 4, payload bytes per write frame (1..255)
WR_CMD, 8'h55, write command byte
RD_CMD, 8'haa, read command byte
CHK_EN, 1, 1 = write frame ends with an XOR checksum byte; 0 = no checksum byte
TIMEOUT_CYC, 50000, idle sclk cycles allowed between bytes inside a frame (>=2)

Ports:
sclk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
uart_flag  in  1  one-cycle strobe, uart_data valid
uart_data  in  DATA_W  received byte
wr_trig  out  1  pulse: valid write frame complete
rd_trig  out  1  pulse: read command received
wfifo_wr_en  out  1  write-FIFO write strobe
wfifo_data  out  DATA_W  write-FIFO data
wfifo_clr  out  1  pulse: flush write FIFO (bad/aborted frame)
frame_err  out  1  pulse: checksum error, timeout or unknown command
cmd_code  out  DATA_W  last accepted command byte

Behaviour:
- One clock (sclk); reset is asynchronous and active-low (s_rst_n). All outputs are registered. Reset value of every output is 0. The state machine resets to IDLE; byte counter, checksum accumulator and timeout counter reset to 0.
- Latency: every output responds 1 cycle after the sclk edge that samples uart_flag=1.
- States: IDLE, PAYLOAD, CHECK.
- IDLE behaviour on uart_flag:
  - data==RD_CMD: rd_trig pulse, cmd_code<=data, stay in IDLE.
  - data==WR_CMD: cmd_code<=data, chk<=data, cnt<=0, go to PAYLOAD.
  - any other byte: frame_err pulse, stay in IDLE, cmd_code unchanged.
- PAYLOAD behaviour on uart_flag:
  - wfifo_wr_en pulse, wfifo_data<=uart_data, chk<=chk^data, cnt<=cnt+1.
  - On byte PAYLOAD_NUM: if CHK_EN=1, go to CHECK; else pulse wr_trig and go to IDLE.
- CHECK behaviour on uart_flag:
  - data==chk: wr_trig pulse.
  - otherwise: frame_err and wfifo_clr pulse together.
  - Either way, go to IDLE. The checksum byte is never written to the FIFO.
- Inside a frame, RD_CMD/WR_CMD values are treated as ordinary data. There is no resynchronisation on header bytes.
- Timeout:
  - The counter runs only in PAYLOAD/CHECK and clears on every uart_flag.
  - When it reaches TIMEOUT_CYC-1 with no flag: pulse frame_err and wfifo_clr, go to IDLE.
  - If uart_flag arrives in the same cycle as the terminal count, the flag wins and no timeout occurs.
- wfifo_data holds its last value when wfifo_wr_en=0.
- wr_trig, rd_trig and wfifo_clr are mutually exclusive in any cycle.
- Counter widths: cnt is $clog2(PAYLOAD_NUM+1) bits; the timeout counter is $clog2(TIMEOUT_CYC) bits. Neither counter wraps.
- Reset mid-frame discards the frame with no wfifo_clr pulse. The FIFO owner is reset by the same s_rst_n.
- Back-to-back frames are allowed: a new command byte may arrive on the first uart_flag after returning to IDLE.

Test Plan:
- CHK_EN=1, PAYLOAD_NUM=4, send 55 11 22 33 44 11 -> 4 wfifo_wr_en pulses with data 11,22,33,44; then wr_trig=1 one cycle after the 6th flag; frame_err=0; cmd_code=55.
- Send aa -> rd_trig=1 one cycle after the flag; no wfifo_wr_en; cmd_code=aa.
- Send 55 11 22 33 44 12 -> 4 FIFO writes, then frame_err=1 and wfifo_clr=1 in the same cycle; wr_trig stays 0; state returns to IDLE (verify by sending aa -> rd_trig).
- TIMEOUT_CYC=100, send 55 11, then wait -> frame_err and wfifo_clr pulse exactly 100 cycles after the last flag; send a flag exactly at the terminal cycle -> no error.
- Send 3c in IDLE -> frame_err pulse; cmd_code unchanged.
- CHK_EN=0, send 55 aa 55 aa 55 aa -> payload aa,55,aa,55 written to the FIFO; wr_trig after the 5th byte; 6th byte aa -> rd_trig.
- Assert s_rst_n low after 55 11 -> all outputs 0; a subsequent aa yields rd_trig.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: recognises write/read command frames from a UART byte
// stream, forwards write payload to the SDRAM write FIFO, checks an optional
// XOR checksum, enforces an inter-byte timeout and reports bad frames.
module uart_cmd_parser #(
  parameter int                DATA_W      = 8,
  parameter int                PAYLOAD_NUM = 4,
  parameter logic [DATA_W-1:0] WR_CMD      = 8'h55,
  parameter logic [DATA_W-1:0] RD_CMD      = 8'haa,
  parameter int                CHK_EN      = 1,
  parameter int                TIMEOUT_CYC = 50000
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              uart_flag,
  input  logic [DATA_W-1:0] uart_data,
  output logic              wr_trig,
  output logic              rd_trig,
  output logic              wfifo_wr_en,
  output logic [DATA_W-1:0] wfifo_data,
  output logic              wfifo_clr,
  output logic              frame_err,
  output logic [DATA_W-1:0] cmd_code
);

  localparam int CNT_W = $clog2(PAYLOAD_NUM + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] chk;
  logic [TO_W-1:0]   tcnt;

  // Frame state machine; all outputs are registered and pulses last one cycle.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      wfifo_clr   <= 1'b0;
      frame_err   <= 1'b0;
      cmd_code    <= '0;
    end else begin
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      wfifo_wr_en <= 1'b0;
      wfifo_clr   <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (uart_flag) begin
            if (uart_data == RD_CMD) begin
              rd_trig  <= 1'b1;
              cmd_code <= uart_data;
            end else if (uart_data == WR_CMD) begin
              cmd_code <= uart_data;
              chk      <= uart_data;
              cnt      <= '0;
              state    <= PAYLOAD;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (uart_flag) begin
            // Header values inside a frame are plain data: no resync.
            tcnt        <= '0;
            wfifo_wr_en <= 1'b1;
            wfifo_data  <= uart_data;
            chk         <= chk ^ uart_data;
            cnt         <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              if (CHK_EN != 0) begin
                state <= CHECK;
              end else begin
                wr_trig <= 1'b1;
                state   <= IDLE;
              end
            end
          end else if (tcnt == TO_LAST) begin
            frame_err <= 1'b1;
            wfifo_clr <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        CHECK: begin
          if (uart_flag) begin
            // The checksum byte itself never reaches the FIFO.
            tcnt <= '0;
            if (uart_data == chk) begin
              wr_trig <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              wfifo_clr <= 1'b1;
            end
            state <= IDLE;
          end else if (tcnt == TO_LAST) begin
            frame_err <= 1'b1;
            wfifo_clr <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: two instances (checksum on / off) share one
// randomized byte stream; a frame-level model predicts every output each cycle.
module tb_uart_cmd_parser;

  localparam int P  = 4;
  localparam int TO = 100;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       uart_flag = 1'b0;
  logic [7:0] uart_data = 8'h00;

  logic       a_wr_trig, a_rd_trig, a_wr_en, a_clr, a_err;
  logic [7:0] a_wdata, a_cmd;
  logic       b_wr_trig, b_rd_trig, b_wr_en, b_clr, b_err;
  logic [7:0] b_wdata, b_cmd;

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b0;

  always #5 sclk = ~sclk;

  uart_cmd_parser #(.DATA_W(8), .PAYLOAD_NUM(P), .WR_CMD(8'h55), .RD_CMD(8'haa),
                    .CHK_EN(1), .TIMEOUT_CYC(TO)) dut_a (
    .sclk(sclk), .s_rst_n(s_rst_n), .uart_flag(uart_flag), .uart_data(uart_data),
    .wr_trig(a_wr_trig), .rd_trig(a_rd_trig), .wfifo_wr_en(a_wr_en),
    .wfifo_data(a_wdata), .wfifo_clr(a_clr), .frame_err(a_err), .cmd_code(a_cmd));

  uart_cmd_parser #(.DATA_W(8), .PAYLOAD_NUM(P), .WR_CMD(8'h55), .RD_CMD(8'haa),
                    .CHK_EN(0), .TIMEOUT_CYC(TO)) dut_b (
    .sclk(sclk), .s_rst_n(s_rst_n), .uart_flag(uart_flag), .uart_data(uart_data),
    .wr_trig(b_wr_trig), .rd_trig(b_rd_trig), .wfifo_wr_en(b_wr_en),
    .wfifo_data(b_wdata), .wfifo_clr(b_clr), .frame_err(b_err), .cmd_code(b_cmd));

  // Frame-level model: bytes collected so far, idle gap length, expected outputs.
  typedef struct {
    bit         in_frame;
    int         n;
    logic [7:0] hdr;
    logic [7:0] pl [P];
    int         idle;
    logic       wr_trig, rd_trig, wr_en, clr, err;
    logic [7:0] wdata, cmd;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.in_frame = 1'b0; r.n = 0; r.hdr = 8'h00; r.idle = 0;
    for (int i = 0; i < P; i++) r.pl[i] = 8'h00;
    r.wr_trig = 1'b0; r.rd_trig = 1'b0; r.wr_en = 1'b0; r.clr = 1'b0; r.err = 1'b0;
    r.wdata = 8'h00; r.cmd = 8'h00;
    return r;
  endfunction

  function automatic model_t model_next(model_t s, bit chk_en, bit flag, logic [7:0] d);
    model_t r;
    logic [7:0] x;
    r = s;
    r.wr_trig = 1'b0; r.rd_trig = 1'b0; r.wr_en = 1'b0; r.clr = 1'b0; r.err = 1'b0;
    if (!s.in_frame) begin
      if (flag) begin
        if (d == 8'haa) begin
          r.rd_trig = 1'b1; r.cmd = d;
        end else if (d == 8'h55) begin
          r.in_frame = 1'b1; r.n = 0; r.hdr = d; r.idle = 0; r.cmd = d;
        end else begin
          r.err = 1'b1;
        end
      end
    end else if (flag) begin
      r.idle = 0;
      if (s.n < P) begin
        r.pl[s.n] = d; r.n = s.n + 1; r.wr_en = 1'b1; r.wdata = d;
        if (r.n == P && !chk_en) begin
          r.wr_trig = 1'b1; r.in_frame = 1'b0;
        end
      end else begin
        x = s.hdr;
        for (int i = 0; i < P; i++) x = x ^ s.pl[i];
        if (d == x) r.wr_trig = 1'b1;
        else begin r.err = 1'b1; r.clr = 1'b1; end
        r.in_frame = 1'b0;
      end
    end else begin
      r.idle = s.idle + 1;
      if (r.idle == TO) begin
        r.err = 1'b1; r.clr = 1'b1; r.in_frame = 1'b0;
      end
    end
    return r;
  endfunction

  model_t ma, mb;

  // Advance both models on every sampling edge; reset clears them immediately.
  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_next(ma, 1'b1, uart_flag, uart_data);
      mb <= model_next(mb, 1'b0, uart_flag, uart_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string t, input model_t m,
                         input logic wt, input logic rt, input logic we, input logic [7:0] wd,
                         input logic cl, input logic er, input logic [7:0] cm);
    check({t, ".wr_trig"}, 32'(wt), 32'(m.wr_trig));
    check({t, ".rd_trig"}, 32'(rt), 32'(m.rd_trig));
    check({t, ".wfifo_wr_en"}, 32'(we), 32'(m.wr_en));
    check({t, ".wfifo_data"}, 32'(wd), 32'(m.wdata));
    check({t, ".wfifo_clr"}, 32'(cl), 32'(m.clr));
    check({t, ".frame_err"}, 32'(er), 32'(m.err));
    check({t, ".cmd_code"}, 32'(cm), 32'(m.cmd));
    check({t, ".exclusive"}, 32'(32'(wt) + 32'(rt) + 32'(cl) <= 32'd1), 32'd1);
  endtask

  // Compare every output of both instances against the model away from the active edge.
  always @(negedge sclk) begin
    if (run) begin
      cmp_dut("a", ma, a_wr_trig, a_rd_trig, a_wr_en, a_wdata, a_clr, a_err, a_cmd);
      cmp_dut("b", mb, b_wr_trig, b_rd_trig, b_wr_en, b_wdata, b_clr, b_err, b_cmd);
    end
  end

  task automatic send(input logic [7:0] d);
    uart_flag = 1'b1;
    uart_data = d;
    @(negedge sclk);
    uart_flag = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  initial begin
    logic [7:0] fr [P];
    logic [7:0] x;
    int k;
    wait_cyc(3);
    run = 1'b1;
    check("lit.reset.cmd_code", 32'(a_cmd), 32'h0);
    check("lit.reset.wfifo_data", 32'(a_wdata), 32'h0);
    s_rst_n = 1'b1;
    wait_cyc(2);

    // Good checksum frame.
    send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("lit.good.wfifo_data", 32'(a_wdata), 32'h44);
    check("lit.good.wfifo_wr_en", 32'(a_wr_en), 32'h1);
    check("lit.nochk.wr_trig_after_4", 32'(b_wr_trig), 32'h1);
    send(8'h11);
    check("lit.good.wr_trig", 32'(a_wr_trig), 32'h1);
    check("lit.good.frame_err", 32'(a_err), 32'h0);
    check("lit.good.cmd_code", 32'(a_cmd), 32'h55);
    check("lit.good.no_write_of_chk", 32'(a_wr_en), 32'h0);
    wait_cyc(2);

    // Read command.
    send(8'haa);
    check("lit.rd.rd_trig", 32'(a_rd_trig), 32'h1);
    check("lit.rd.cmd_code", 32'(a_cmd), 32'haa);
    wait_cyc(2);

    // Bad checksum.
    send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h12);
    check("lit.bad.frame_err", 32'(a_err), 32'h1);
    check("lit.bad.wfifo_clr", 32'(a_clr), 32'h1);
    check("lit.bad.wr_trig", 32'(a_wr_trig), 32'h0);
    send(8'haa);
    check("lit.bad.back_to_idle", 32'(a_rd_trig), 32'h1);
    wait_cyc(2);

    // Timeout exactly TO cycles after the last flag.
    send(8'h55); send(8'h11);
    wait_cyc(TO - 1);
    check("lit.timeout.early", 32'(a_err), 32'h0);
    wait_cyc(1);
    check("lit.timeout.frame_err", 32'(a_err), 32'h1);
    check("lit.timeout.wfifo_clr", 32'(a_clr), 32'h1);
    wait_cyc(2);

    // Flag on the terminal cycle beats the timeout.
    send(8'h55); send(8'h11);
    wait_cyc(TO - 1);
    send(8'h22);
    check("lit.terminal.no_err", 32'(a_err), 32'h0);
    check("lit.terminal.wr_en", 32'(a_wr_en), 32'h1);
    send(8'h33); send(8'h44); send(8'h11);
    check("lit.terminal.wr_trig", 32'(a_wr_trig), 32'h1);
    wait_cyc(2);

    // Unknown command in IDLE.
    send(8'h3c);
    check("lit.junk.frame_err", 32'(a_err), 32'h1);
    check("lit.junk.cmd_code", 32'(a_cmd), 32'h55);
    wait_cyc(TO + 5);

    // Header values as payload, no checksum.
    send(8'h55); send(8'haa); send(8'h55); send(8'haa); send(8'h55);
    check("lit.nochk.wr_trig", 32'(b_wr_trig), 32'h1);
    check("lit.nochk.wfifo_data", 32'(b_wdata), 32'h55);
    send(8'haa);
    check("lit.nochk.rd_trig", 32'(b_rd_trig), 32'h1);
    wait_cyc(TO + 5);

    // Reset mid-frame.
    send(8'h55); send(8'h11);
    s_rst_n = 1'b0;
    wait_cyc(1);
    check("lit.rst.wfifo_data", 32'(a_wdata), 32'h0);
    check("lit.rst.cmd_code", 32'(a_cmd), 32'h0);
    check("lit.rst.wfifo_clr", 32'(a_clr), 32'h0);
    s_rst_n = 1'b1;
    wait_cyc(1);
    send(8'haa);
    check("lit.rst.rd_trig", 32'(a_rd_trig), 32'h1);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 4) begin
        send(8'h55);
        x = 8'h55;
        for (int i = 0; i < P; i++) begin
          fr[i] = 8'($urandom);
          x = x ^ fr[i];
          wait_cyc(int'($urandom_range(0, 2)));
          send(fr[i]);
        end
        wait_cyc(int'($urandom_range(0, 2)));
        if ($urandom_range(0, 1) == 0) send(x);
        else send(x ^ 8'($urandom_range(1, 255)));
      end else if (k <= 6) begin
        send(8'haa);
      end else if (k == 7) begin
        send(8'($urandom));
      end else if (k == 8) begin
        wait_cyc(int'($urandom_range(TO - 5, TO + 5)));
      end else begin
        wait_cyc(int'($urandom_range(0, 3)));
      end
    end
    wait_cyc(TO + 5);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
